// File: rtl/hbm_apb_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hbm_apb_cmd_master                                               |
// | Purpose : Valid/ready command stream to single APB transfers on the HBM    |
// |           user APB port, gated by calibration, with access timeout.        |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module hbm_apb_cmd_master #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int STRB_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cal_success,
  input  logic              cal_fail,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ur_paddr,
  output logic              ur_psel,
  output logic              ur_penable,
  output logic              ur_pwrite,
  output logic [DATA_W-1:0] ur_pwdata,
  output logic [STRB_W-1:0] ur_pstrb,
  input  logic              ur_prready,
  input  logic [DATA_W-1:0] ur_prdata,
  output logic              busy,
  output logic [15:0]       err_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_cmd_ready;
  logic              w_accept;
  logic              w_done_ok;
  logic              w_timeout;

  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic [STRB_W-1:0] r_pstrb;
  logic [15:0]       r_tmo_cnt;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic [15:0]       r_err_count;

  // Calibration only gates acceptance; an in-flight transfer always completes.
  assign w_cmd_ready = (r_state == ST_IDLE) && cal_success && !cal_fail;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done_ok   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && w_cmd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A ready on the last counted cycle still wins over the timeout.
        if (ur_prready) begin
          w_done_ok   = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (r_tmo_cnt == c_TMO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_tmo_cnt   <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_accept) begin
        r_paddr  <= cmd_addr;
        r_pwrite <= cmd_write;
        r_pwdata <= cmd_write ? cmd_wdata : '0;
        r_pstrb  <= cmd_write ? cmd_strb  : '0;
      end

      if (r_state == ST_SETUP) begin
        r_tmo_cnt <= '0;
      end else if (r_state == ST_ACCESS) begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end

      if (w_done_ok) begin
        r_rsp_rdata <= r_pwrite ? '0 : ur_prdata;
        r_rsp_err   <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b1;
        if (r_err_count != 16'hFFFF) begin
          r_err_count <= r_err_count + 16'd1;
        end
      end
    end
  end

  assign cmd_ready  = w_cmd_ready;
  assign busy       = (r_state != ST_IDLE);
  assign ur_psel    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign ur_penable = (r_state == ST_ACCESS);
  assign ur_paddr   = r_paddr;
  assign ur_pwrite  = r_pwrite;
  assign ur_pwdata  = r_pwdata;
  assign ur_pstrb   = r_pstrb;
  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: doc/hbm_apb_cmd_master.md
Name: hbm_apb_cmd_master

Overview:
- APB master that drives the HBM controller user APB port (ur_paddr/ur_psel/ur_penable/ur_pwrite/ur_pwdata/ur_pstrb in; ur_prready/ur_prdata back). Sits directly upstream of the HBM subsystem APB slave.
- Converts a valid/ready command stream from fabric logic into single APB transfers. Returns read data and a timeout error on a valid/ready response channel.
- Holds off all commands until HBM calibration reports success.

Parameters:
- ADDR_W, 16, APB address width.
- DATA_W, 16, APB data width; STRB_W = DATA_W/8.
- TIMEOUT_CYCLES, 1024, maximum ACCESS-phase cycles to wait for ur_prready before aborting; legal range 2..65535.

Ports:
- clk  in  1  single clock for all logic and the APB interface.
- reset  in  1  synchronous, active-high.
- cal_success  in  1  HBM local_cal_success.
- cal_fail  in  1  HBM local_cal_fail.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid & ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  register address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  STRB_W  byte strobes; ignored for reads (driven 0).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  1 = transfer timed out.
- ur_paddr  out  ADDR_W
- ur_psel  out  1
- ur_penable  out  1
- ur_pwrite  out  1
- ur_pwdata  out  DATA_W
- ur_pstrb  out  STRB_W
- ur_prready  in  1
- ur_prdata  in  DATA_W
- busy  out  1  state != IDLE.
- err_count  out  16  number of timeouts; saturates at 0xFFFF.

Behaviour:
- Reset:
  - Synchronous, active-high, wins over all other inputs.
  - State = IDLE; all outputs 0, including the ur_* buses, rsp_* and err_count.
  - Reset mid-transfer drops psel/penable on the next edge and discards any pending response.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- cmd_ready = (state == IDLE) & cal_success & ~cal_fail. It is combinational from the registered state and the cal inputs.
- IDLE -> SETUP on cmd_valid & cmd_ready:
  - Register addr, write, wdata and strb onto the ur_* outputs. For reads, ur_pstrb = 0 and ur_pwdata = 0.
- SETUP (exactly 1 cycle): ur_psel = 1, ur_penable = 0 -> ACCESS.
- ACCESS: ur_psel = 1, ur_penable = 1. A timeout counter starts at 0 on entry and increments each cycle.
  - ur_prready sampled 1 -> RESP.
    - Reads capture ur_prdata into rsp_rdata.
    - rsp_err = 0.
    - psel/penable drop to 0 in the same edge.
  - Counter reaches TIMEOUT_CYCLES-1 with ur_prready still 0 -> RESP with rsp_err = 1 and rsp_rdata = 0.
    - psel/penable drop.
    - err_count increments, saturating.
  - If ur_prready arrives on the final counted cycle, the transfer succeeds; there is no timeout.
- RESP: rsp_valid = 1, with rsp_rdata and rsp_err held stable until rsp_ready. On rsp_valid & rsp_ready -> IDLE.
- APB address, control and data outputs stay stable from SETUP through the last ACCESS cycle. Between transfers, ur_paddr, ur_pwdata and ur_pstrb hold their last value; psel/penable are 0.
- Latency:
  - Accept at edge N; SETUP in cycle N+1; first ACCESS in cycle N+2.
  - With zero-wait slave (prready=1 in first ACCESS): rsp_valid from cycle N+3.
  - Minimum command-to-command spacing is 4 cycles when rsp_ready is held high.
- Calibration events:
  - A drop of cal_success, or assertion of cal_fail, during SETUP/ACCESS/RESP does not abort the transfer; only new acceptance is blocked.
  - cal_fail = 1 blocks acceptance even if cal_success = 1.
- Exactly one outstanding transfer; no command queuing.
- busy = 1 in SETUP, ACCESS and RESP.

Test Plan:
- Reset, then cal_success=0 with cmd_valid=1 -> cmd_ready stays 0 and ur_psel stays 0 for 20 cycles. Raise cal_success -> accepted the next cycle.
- Write addr=0x0010, wdata=0xA5A5, strb=2'b11, zero-wait slave -> psel high in cycles N+1..N+2, penable high in N+2 only. pwrite=1 throughout. rsp_valid at N+3 with err=0 and rdata=0.
- Read addr=0x0024, slave inserts 5 wait states then returns prready with prdata=0x1234 -> addr/pwrite stable all 6 ACCESS cycles. rsp_rdata=0x1234, err=0.
- TIMEOUT_CYCLES=8, slave never asserts prready -> exactly 8 ACCESS cycles, psel drops, rsp_err=1, rsp_rdata=0, err_count=1. The next command is accepted normally.
- rsp_ready held 0 for 10 cycles after a completed read -> rsp_valid, rdata and err stay stable, cmd_ready stays 0. Release -> IDLE next cycle.
- reset asserted in the 3rd ACCESS cycle of a waited read -> psel/penable/rsp_valid are 0 on the next edge, err_count=0, no response is delivered. Assert cal_fail=1 with cal_success=1 -> cmd_ready=0.
